// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register.
// Captures execute-stage results and drives the MEM stage and the forwarding network.
// Branches resolve here: a taken branch in MEM redirects fetch and squashes the
// younger instruction leaving EX. Saturating counters track taken branches and bubbles.
module ex_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Valid_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              Branch_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [DATA_W-1:0] ALUAddResult_in,
    input  logic              Zero_in,
    input  logic [DATA_W-1:0] ALUResult_in,
    input  logic [DATA_W-1:0] ReadData2_in,
    input  logic [REG_W-1:0]  WriteReg_in,
    output logic              Valid_out,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic              MemRead_out,
    output logic              MemWrite_out,
    output logic [DATA_W-1:0] ALUResult_out,
    output logic [DATA_W-1:0] ReadData2_out,
    output logic [REG_W-1:0]  WriteReg_out,
    output logic              PCSrc_out,
    output logic [DATA_W-1:0] BranchTarget_out,
    output logic              FlushFront_out,
    output logic              Fwd_RegWrite,
    output logic [REG_W-1:0]  Fwd_WriteReg,
    output logic [DATA_W-1:0] Fwd_Data,
    output logic [CNT_W-1:0]  TakenCount,
    output logic [CNT_W-1:0]  BubbleCount
);

    logic              valid_reg, regwrite_reg, memtoreg_reg, memread_reg, memwrite_reg;
    logic              branch_reg, zero_reg;
    logic [DATA_W-1:0] alu_reg, rd2_reg, target_reg;
    logic [REG_W-1:0]  wreg_reg;

    logic              valid_next, regwrite_next, memtoreg_next, memread_next, memwrite_next;
    logic              branch_next, zero_next;
    logic [DATA_W-1:0] alu_next, rd2_next, target_next;
    logic [REG_W-1:0]  wreg_next;

    logic              taken;
    logic              pcsrc;
    logic              load_bubble;
    logic [1:0]        cnt_inc;
    logic [CNT_W-1:0]  cnt_reg [2];

    // A taken branch only redirects when the stage is actually advancing, so a
    // stalled branch waits and fires exactly once when the stall lifts.
    assign taken       = valid_reg & branch_reg & zero_reg;
    assign pcsrc       = taken & ~Stall & ~Flush;
    // Flush wins over stall; the redirect squashes the wrong-path instruction in EX.
    assign load_bubble = Flush | pcsrc;

    // Counter 0 counts redirects, counter 1 counts every bubble entering the stage
    // (flush, self-squash, or an empty slot captured from EX).
    assign cnt_inc[0] = pcsrc;
    assign cnt_inc[1] = Flush | (~Stall & (pcsrc | ~Valid_in));

    // Next-state selection: bubble, hold, or capture with control gated by Valid_in.
    always_comb begin
        valid_next    = valid_reg;
        regwrite_next = regwrite_reg;
        memtoreg_next = memtoreg_reg;
        memread_next  = memread_reg;
        memwrite_next = memwrite_reg;
        branch_next   = branch_reg;
        zero_next     = zero_reg;
        alu_next      = alu_reg;
        rd2_next      = rd2_reg;
        target_next   = target_reg;
        wreg_next     = wreg_reg;
        if (load_bubble) begin
            valid_next    = 1'b0;
            regwrite_next = 1'b0;
            memtoreg_next = 1'b0;
            memread_next  = 1'b0;
            memwrite_next = 1'b0;
            branch_next   = 1'b0;
            zero_next     = 1'b0;
            alu_next      = '0;
            rd2_next      = '0;
            target_next   = '0;
            wreg_next     = '0;
        end else if (!Stall) begin
            valid_next    = Valid_in;
            regwrite_next = RegWrite_in & Valid_in;
            memtoreg_next = MemtoReg_in & Valid_in;
            memread_next  = MemRead_in  & Valid_in;
            memwrite_next = MemWrite_in & Valid_in;
            branch_next   = Branch_in   & Valid_in;
            zero_next     = Zero_in;
            alu_next      = ALUResult_in;
            rd2_next      = ReadData2_in;
            target_next   = ALUAddResult_in;
            wreg_next     = WriteReg_in;
        end
    end

    // Pipeline state register with asynchronous clear.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            memread_reg  <= 1'b0;
            memwrite_reg <= 1'b0;
            branch_reg   <= 1'b0;
            zero_reg     <= 1'b0;
            alu_reg      <= '0;
            rd2_reg      <= '0;
            target_reg   <= '0;
            wreg_reg     <= '0;
        end else begin
            valid_reg    <= valid_next;
            regwrite_reg <= regwrite_next;
            memtoreg_reg <= memtoreg_next;
            memread_reg  <= memread_next;
            memwrite_reg <= memwrite_next;
            branch_reg   <= branch_next;
            zero_reg     <= zero_next;
            alu_reg      <= alu_next;
            rd2_reg      <= rd2_next;
            target_reg   <= target_next;
            wreg_reg     <= wreg_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            // Saturating event counter; sticks at all-ones instead of wrapping.
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign Valid_out        = valid_reg;
    assign RegWrite_out     = regwrite_reg;
    assign MemtoReg_out     = memtoreg_reg;
    assign MemRead_out      = memread_reg;
    assign MemWrite_out     = memwrite_reg;
    assign ALUResult_out    = alu_reg;
    assign ReadData2_out    = rd2_reg;
    assign WriteReg_out     = wreg_reg;
    assign PCSrc_out        = pcsrc;
    assign FlushFront_out   = pcsrc;
    assign BranchTarget_out = target_reg;
    // Writes to register 0 are never forwarded.
    assign Fwd_RegWrite     = valid_reg & regwrite_reg & (wreg_reg != '0);
    assign Fwd_WriteReg     = wreg_reg;
    assign Fwd_Data         = alu_reg;
    assign TakenCount       = cnt_reg[0];
    assign BubbleCount      = cnt_reg[1];

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed scenarios with literal
// expectations plus a per-cycle comparison against a stage-contents model.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_ex_mem_pipe_reg;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, Valid_in;
    logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Zero_in;
    logic [31:0] ALUAddResult_in, ALUResult_in, ReadData2_in;
    logic [4:0]  WriteReg_in;

    logic        Valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
    logic [31:0] ALUResult_out, ReadData2_out, BranchTarget_out, Fwd_Data;
    logic [4:0]  WriteReg_out, Fwd_WriteReg;
    logic        PCSrc_out, FlushFront_out, Fwd_RegWrite;
    logic [15:0] TakenCount, BubbleCount;

    logic        s_valid, s_regwrite, s_memtoreg, s_memread, s_memwrite;
    logic [31:0] s_alu, s_rd2, s_target, s_fwd_data;
    logic [4:0]  s_wreg, s_fwd_wreg;
    logic        s_pcsrc, s_flushfront, s_fwd_regwrite;
    logic [1:0]  s_taken, s_bubble;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .Valid_in(Valid_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .ALUAddResult_in(ALUAddResult_in),
        .Zero_in(Zero_in), .ALUResult_in(ALUResult_in), .ReadData2_in(ReadData2_in),
        .WriteReg_in(WriteReg_in), .Valid_out(Valid_out), .RegWrite_out(RegWrite_out),
        .MemtoReg_out(MemtoReg_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .ALUResult_out(ALUResult_out), .ReadData2_out(ReadData2_out), .WriteReg_out(WriteReg_out),
        .PCSrc_out(PCSrc_out), .BranchTarget_out(BranchTarget_out), .FlushFront_out(FlushFront_out),
        .Fwd_RegWrite(Fwd_RegWrite), .Fwd_WriteReg(Fwd_WriteReg), .Fwd_Data(Fwd_Data),
        .TakenCount(TakenCount), .BubbleCount(BubbleCount)
    );

    ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .Valid_in(Valid_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .ALUAddResult_in(ALUAddResult_in),
        .Zero_in(Zero_in), .ALUResult_in(ALUResult_in), .ReadData2_in(ReadData2_in),
        .WriteReg_in(WriteReg_in), .Valid_out(s_valid), .RegWrite_out(s_regwrite),
        .MemtoReg_out(s_memtoreg), .MemRead_out(s_memread), .MemWrite_out(s_memwrite),
        .ALUResult_out(s_alu), .ReadData2_out(s_rd2), .WriteReg_out(s_wreg),
        .PCSrc_out(s_pcsrc), .BranchTarget_out(s_target), .FlushFront_out(s_flushfront),
        .Fwd_RegWrite(s_fwd_regwrite), .Fwd_WriteReg(s_fwd_wreg), .Fwd_Data(s_fwd_data),
        .TakenCount(s_taken), .BubbleCount(s_bubble)
    );

    // ---------------- model: what instruction sits in MEM, and event tallies ----------------
    typedef struct packed {
        logic        valid, regwrite, memtoreg, memread, memwrite, branch, zero;
        logic [31:0] alu, rd2, target;
        logic [4:0]  wreg;
    } slot_t;

    slot_t m;
    int    m_taken;
    int    m_bubbles;

    function automatic logic m_redirect();
        return m.valid && m.branch && m.zero && !Stall && !Flush;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m = '0;
            m_taken = 0;
            m_bubbles = 0;
        end else if (Flush) begin
            m = '0;
            m_bubbles++;
        end else if (!Stall) begin
            if (m_redirect()) begin
                m = '0;
                m_taken++;
                m_bubbles++;
            end else begin
                m.valid    = Valid_in;
                m.regwrite = Valid_in && RegWrite_in;
                m.memtoreg = Valid_in && MemtoReg_in;
                m.memread  = Valid_in && MemRead_in;
                m.memwrite = Valid_in && MemWrite_in;
                m.branch   = Valid_in && Branch_in;
                m.zero     = Zero_in;
                m.alu      = ALUResult_in;
                m.rd2      = ReadData2_in;
                m.target   = ALUAddResult_in;
                m.wreg     = WriteReg_in;
                if (!Valid_in) m_bubbles++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        check("valid",     32'(Valid_out),     32'(m.valid));
        check("regwrite",  32'(RegWrite_out),  32'(m.regwrite));
        check("memtoreg",  32'(MemtoReg_out),  32'(m.memtoreg));
        check("memread",   32'(MemRead_out),   32'(m.memread));
        check("memwrite",  32'(MemWrite_out),  32'(m.memwrite));
        check("alu",       ALUResult_out,      m.alu);
        check("rd2",       ReadData2_out,      m.rd2);
        check("wreg",      32'(WriteReg_out),  32'(m.wreg));
        check("target",    BranchTarget_out,   m.target);
        check("pcsrc",     32'(PCSrc_out),     32'(m_redirect()));
        check("flushfront",32'(FlushFront_out),32'(m_redirect()));
        check("fwd_rw",    32'(Fwd_RegWrite),  32'(m.valid && m.regwrite && (m.wreg != 5'd0)));
        check("fwd_wreg",  32'(Fwd_WriteReg),  32'(m.wreg));
        check("fwd_data",  Fwd_Data,           m.alu);
        check("taken_cnt", 32'(TakenCount),    32'(sat(m_taken, 65535)));
        check("bubble_cnt",32'(BubbleCount),   32'(sat(m_bubbles, 65535)));
        check("taken_sat", 32'(s_taken),       32'(sat(m_taken, 3)));
        check("bubble_sat",32'(s_bubble),      32'(sat(m_bubbles, 3)));
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr2, input logic br,
                         input logic mrd, input logic mw, input logic z,
                         input logic [31:0] tgt, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [4:0] wr);
        Valid_in = v; RegWrite_in = rw; MemtoReg_in = mr2; Branch_in = br;
        MemRead_in = mrd; MemWrite_in = mw; Zero_in = z;
        ALUAddResult_in = tgt; ALUResult_in = alu; ReadData2_in = rd2; WriteReg_in = wr;
        $display("txn t=%0t v=%0b rw=%0b br=%0b z=%0b mw=%0b tgt=%0h alu=%0h wr=%0d stall=%0b flush=%0b",
                 $time, v, rw, br, z, mw, tgt, alu, wr, Stall, Flush);
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        // Reset state
        check("rst_valid",  32'(Valid_out), 32'h0);
        check("rst_alu",    ALUResult_out,  32'h0);
        check("rst_pcsrc",  32'(PCSrc_out), 32'h0);
        check("rst_fwd",    32'(Fwd_RegWrite), 32'h0);
        check("rst_bcnt",   32'(BubbleCount), 32'h0);

        // Capture after reset
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_00A5, 32'h0, 5'd8);
        Rst = 1'b0;
        tick();
        check("cap_alu",    ALUResult_out, 32'hA5);
        check("cap_fwd_rw", 32'(Fwd_RegWrite), 32'h1);
        check("cap_fwd_wr", 32'(Fwd_WriteReg), 32'h8);

        // Taken branch: one pulse, then self-squash
        drive(1, 0, 0, 1, 0, 0, 1, 32'h0000_0040, 32'h0, 32'h0, 5'd0);
        tick();
        check("br_pcsrc",   32'(PCSrc_out), 32'h1);
        check("br_target",  BranchTarget_out, 32'h40);
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h55, 32'h0, 5'd3);
        tick();
        check("sq_valid",   32'(Valid_out), 32'h0);
        check("sq_pcsrc",   32'(PCSrc_out), 32'h0);
        check("sq_tcnt",    32'(TakenCount), 32'h1);
        check("sq_bcnt",    32'(BubbleCount), 32'h1);

        // Branch held under stall for three cycles
        drive(1, 0, 0, 1, 0, 0, 1, 32'h0000_0080, 32'h0, 32'h0, 5'd0);
        tick();
        check("bs_pcsrc0",  32'(PCSrc_out), 32'h1);
        Stall = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h66, 32'h0, 5'd4);
        #1;
        check("bs_pcsrc_st", 32'(PCSrc_out), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bs_hold_pc",  32'(PCSrc_out), 32'h0);
            check("bs_hold_tgt", BranchTarget_out, 32'h80);
            check("bs_hold_v",   32'(Valid_out), 32'h1);
        end
        Stall = 1'b0;
        #1;
        check("bs_release", 32'(PCSrc_out), 32'h1);
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h77, 32'h0, 5'd5);
        tick();
        check("bs_sq_valid", 32'(Valid_out), 32'h0);
        check("bs_tcnt",     32'(TakenCount), 32'h2);
        check("bs_bcnt",     32'(BubbleCount), 32'h2);

        // $zero suppression, then flush under stall
        drive(1, 1, 0, 0, 0, 1, 0, 32'h0, 32'h1234, 32'hCAFE, 5'd0);
        tick();
        check("z_regwrite", 32'(RegWrite_out), 32'h1);
        check("z_fwd_rw",   32'(Fwd_RegWrite), 32'h0);
        check("z_memwrite", 32'(MemWrite_out), 32'h1);
        Stall = 1'b1; Flush = 1'b1;
        tick();
        check("fs_valid",   32'(Valid_out), 32'h0);
        check("fs_memwrite",32'(MemWrite_out), 32'h0);
        check("fs_bcnt",    32'(BubbleCount), 32'h3);
        Stall = 1'b0; Flush = 1'b0;

        // Invalid capture: controls dropped, data kept
        drive(0, 1, 1, 1, 1, 1, 1, 32'h44, 32'hDEAD, 32'hBEEF, 5'd9);
        tick();
        check("iv_regwrite",32'(RegWrite_out), 32'h0);
        check("iv_memread", 32'(MemRead_out), 32'h0);
        check("iv_alu",     ALUResult_out, 32'hDEAD);
        check("iv_bcnt",    32'(BubbleCount), 32'h4);

        // Reset in the middle of a stalled taken branch
        drive(1, 0, 0, 1, 0, 0, 1, 32'h0000_00C0, 32'h0, 32'h0, 5'd0);
        tick();
        Stall = 1'b1;
        tick();
        #2 Rst = 1'b1;
        #1;
        check("mr_pcsrc",   32'(PCSrc_out), 32'h0);
        check("mr_valid",   32'(Valid_out), 32'h0);
        check("mr_target",  BranchTarget_out, 32'h0);
        check("mr_tcnt",    32'(TakenCount), 32'h0);
        check("mr_bcnt",    32'(BubbleCount), 32'h0);
        Stall = 1'b0;
        tick();
        Rst = 1'b0;

        // Saturation of the 2-bit instance over consecutive flushes
        Flush = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("sat_small",  32'(s_bubble), 32'h3);
        check("sat_big",    32'(BubbleCount), 32'h5);
        tick();
        check("sat_hold",   32'(s_bubble), 32'h3);
        Flush = 1'b0;

        // Mixed traffic, checked cycle by cycle against the model
        for (int i = 0; i < 60; i++) begin
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
            tick();
        end
        Stall = 1'b0; Flush = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
